// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the waveform frame packer: the default frame sync
// word, the frame sequencer state encoding and the header word positions.
// A frame on the USB side is:
//   SYNC_WORD, sequence number, payload length, payload[0..len-1], checksum
// -----------------------------------------------------------------------------
package wave_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

  // Position of each header word within a frame.
  localparam int unsigned HDR_IDX_SYNC = 0;
  localparam int unsigned HDR_IDX_SEQ  = 1;
  localparam int unsigned HDR_IDX_LEN  = 2;
  localparam int unsigned HDR_WORDS    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_SYNC = 3'd1,
    ST_HDR_SEQ  = 3'd2,
    ST_HDR_LEN  = 3'd3,
    ST_PAYLOAD  = 3'd4,
    ST_CKSUM    = 3'd5
  } state_e;

endpackage

// File: rtl/wave_frame_packer.sv
// -----------------------------------------------------------------------------
// wave_frame_packer
// Wraps a block of capture-FIFO words in a frame (sync, sequence number,
// length, payload, 16-bit additive checksum) and writes it to the USB FIFO.
//
// Ports:
//   i_clk, i_rst      system clock / asynchronous active-high reset
//   i_en              run enable; triggers are ignored while low
//   i_st              one-cycle frame start pulse
//   i_recv_count      payload words per frame, sampled on the accepted i_st
//   i_rd_empty        capture FIFO empty
//   i_rd_data         capture FIFO head word (show-ahead)
//   o_rd              capture FIFO pop (combinational)
//   i_full            USB FIFO full (sink keeps one word of slack)
//   o_wr, o_wr_data   registered USB FIFO write strobe and word
//   o_busy            high from the accepted i_st until the checksum is written
//   o_seq             sequence number of the most recently started frame
//   o_drop_cnt        saturating count of triggers rejected while busy
// -----------------------------------------------------------------------------
module wave_frame_packer
  import wave_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          DW        = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_st,
  input  logic [15:0]   i_recv_count,
  input  logic          i_rd_empty,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_rd,
  input  logic          i_full,
  output logic          o_wr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic [15:0]   o_seq,
  output logic [15:0]   o_drop_cnt
);

  state_e        state_q, state_d;
  // Holds the latched length through the header, then counts down the
  // payload words still to be popped.
  logic [15:0]   rem_q,   rem_d;
  logic [DW-1:0] cksum_q, cksum_d;
  logic [15:0]   seq_q,   seq_d;
  logic [15:0]   drop_q,  drop_d;
  logic          busy_q,  busy_d;
  logic          wr_q,    wr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          rd;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    cksum_d   = cksum_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    busy_d    = busy_q;
    wr_d      = 1'b0;
    wr_data_d = wr_data_q;
    rd        = 1'b0;

    // Any trigger outside IDLE is rejected, including one arriving in the
    // same cycle the checksum is issued.
    if (i_st && i_en && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_st && i_en) begin
          rem_d   = i_recv_count;
          seq_d   = seq_q + 16'd1;
          cksum_d = '0;
          busy_d  = 1'b1;
          state_d = ST_HDR_SYNC;
        end
      end

      ST_HDR_SYNC: begin
        if (!i_full) begin
          wr_d      = 1'b1;
          wr_data_d = SYNC_WORD[DW-1:0];
          state_d   = ST_HDR_SEQ;
        end
      end

      ST_HDR_SEQ: begin
        if (!i_full) begin
          wr_d      = 1'b1;
          wr_data_d = DW'(seq_q);
          state_d   = ST_HDR_LEN;
        end
      end

      ST_HDR_LEN: begin
        if (!i_full) begin
          wr_d      = 1'b1;
          wr_data_d = DW'(rem_q);
          state_d   = (rem_q == 16'd0) ? ST_CKSUM : ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        rd = !i_rd_empty && !i_full && (rem_q != 16'd0);
        if (rd) begin
          wr_d      = 1'b1;
          wr_data_d = i_rd_data;
          cksum_d   = cksum_q + i_rd_data;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = ST_CKSUM;
          end
        end
      end

      ST_CKSUM: begin
        if (!i_full) begin
          wr_d      = 1'b1;
          wr_data_d = cksum_q;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      cksum_q   <= '0;
      seq_q     <= 16'hFFFF;  // first frame after reset carries sequence 0
      drop_q    <= '0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cksum_q   <= cksum_d;
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_rd       = rd;
  assign o_wr       = wr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_seq      = seq_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_wave_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_wave_frame_packer
// Self-checking bench. The capture FIFO is a queue; each frame's expected
// word list is built from the frame format (sync, seq, len, payload, sum).
// -----------------------------------------------------------------------------
module tb_wave_frame_packer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_st;
  logic [15:0] i_recv_count;
  logic        i_rd_empty;
  logic [15:0] i_rd_data;
  logic        o_rd;
  logic        i_full;
  logic        o_wr;
  logic [15:0] o_wr_data;
  logic        o_busy;
  logic [15:0] o_seq;
  logic [15:0] o_drop_cnt;

  wave_frame_packer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_st         (i_st),
    .i_recv_count (i_recv_count),
    .i_rd_empty   (i_rd_empty),
    .i_rd_data    (i_rd_data),
    .o_rd         (o_rd),
    .i_full       (i_full),
    .o_wr         (o_wr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_seq        (o_seq),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference state
  logic [15:0] cap_q[$];   // capture FIFO contents
  logic [15:0] pay_q[$];   // payload for the next frame
  logic [15:0] exp_seq;
  logic [15:0] exp_drop;

  // Per-cycle stimulus, indexed by cycle offset from the i_st cycle
  bit full_at [256];
  bit empty_at[256];
  bit st_at   [256];

  // Words observed in the most recent frame
  logic [15:0] got_w[$];
  logic [15:0] last_w[$];

  task automatic clear_stim();
    for (int i = 0; i < 256; i++) begin
      full_at[i]  = 1'b0;
      empty_at[i] = 1'b0;
      st_at[i]    = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check the pop guard, pop the model FIFO on
  // the edge if the DUT popped, then observe the registered outputs.
  task automatic step(input bit st, input bit full, input bit hold_empty,
                      output bit wr, output logic [15:0] data, output bit busy);
    bit rd_now;
    i_st       = st;
    i_full     = full;
    i_rd_empty = hold_empty || (cap_q.size() == 0);
    i_rd_data  = (cap_q.size() != 0) ? cap_q[0] : 16'h0000;
    #1;
    rd_now = o_rd;
    check("rd_guard", {31'd0, rd_now & (i_rd_empty | i_full)}, 32'd0);
    @(posedge i_clk);
    if (rd_now && cap_q.size() != 0) void'(cap_q.pop_front());
    #1;
    wr   = o_wr;
    data = o_wr_data;
    busy = o_busy;
    i_st = 1'b0;
  endtask

  // Runs one accepted frame of len words taken from pay_q. Extra triggers in
  // st_at are only used with no_stall=1, where the busy window is cycles
  // 1..len+4 after the accepting cycle.
  task automatic run_frame(input int len, input bit no_stall, input string name);
    logic [15:0] exp_w[$];
    logic [15:0] sum;
    int          got_off[$];
    bit          wr, busy, done;
    logic [15:0] d;
    int          done_off;
    got_w.delete();
    exp_seq = exp_seq + 16'd1;
    sum     = 16'h0000;
    exp_w.push_back(16'hA55A);
    exp_w.push_back(exp_seq);
    exp_w.push_back(16'(len));
    foreach (pay_q[i]) begin
      exp_w.push_back(pay_q[i]);
      sum = sum + pay_q[i];
      cap_q.push_back(pay_q[i]);
    end
    exp_w.push_back(sum);
    i_recv_count = 16'(len);
    done     = 1'b0;
    done_off = -1;
    for (int off = 0; off < 256 && !done; off++) begin
      if (off >= 1 && st_at[off] && off <= len + 4 && exp_drop != 16'hFFFF)
        exp_drop = exp_drop + 16'd1;
      step(off == 0 || st_at[off], full_at[off], empty_at[off], wr, d, busy);
      if (off == 0) check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
      if (wr) begin
        got_w.push_back(d);
        got_off.push_back(off);
      end
      if (off >= 1 && !busy) begin
        done     = 1'b1;
        done_off = off;
      end
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_word_count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_word%0d", name, i), got_w[i], exp_w[i]);
    if (got_off.size() != 0) begin
      check({name, "_busy_fall"}, got_off[got_off.size()-1], done_off);
      if (no_stall) begin
        check({name, "_first_wr_lat"}, got_off[0], 1);
        check({name, "_contiguous"}, got_off[got_off.size()-1] - got_off[0], len + 3);
      end
    end
    check({name, "_o_seq"}, o_seq, exp_seq);
    check({name, "_drop"}, o_drop_cnt, exp_drop);
    check({name, "_fifo_drained"}, cap_q.size(), 0);
    last_w = got_w;
    pay_q.delete();
    clear_stim();
  endtask

  initial begin
    bit          wr, busy;
    logic [15:0] d;
    int          len;

    clear_stim();
    i_rst = 1'b1; i_en = 1'b1; i_st = 1'b0; i_recv_count = 16'd0;
    i_rd_empty = 1'b0; i_rd_data = 16'h1234; i_full = 1'b0;
    exp_seq = 16'hFFFF; exp_drop = 16'h0000;

    // Reset state
    #12;
    check("rst_wr", {31'd0, o_wr}, 32'd0);
    check("rst_wr_data", o_wr_data, 32'h0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_seq", o_seq, 32'hFFFF);
    check("rst_drop", o_drop_cnt, 32'h0);
    i_st = 1'b1;
    #1;
    check("rst_rd", {31'd0, o_rd}, 32'd0);
    i_st = 1'b0;
    #10 i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Basic frame: 1..4
    for (int i = 1; i <= 4; i++) pay_q.push_back(16'(i));
    run_frame(4, 1'b1, "basic");
    if (last_w.size() == 8) check("basic_cksum_literal", last_w[7], 32'h000A);

    // Back-to-back frames of len 2
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 2; i++) pay_q.push_back(16'($urandom));
      run_frame(2, 1'b1, $sformatf("b2b%0d", f));
    end
    check("b2b_seq_final", o_seq, 32'd3);  // basic frame took seq 0

    // Backpressure during HDR_LEN and empty mid-payload
    for (int i = 0; i < 3; i++) pay_q.push_back(16'($urandom));
    for (int o = 3; o <= 7; o++) full_at[o] = 1'b1;
    for (int o = 10; o <= 12; o++) empty_at[o] = 1'b1;
    run_frame(3, 1'b0, "stall");

    // Zero length, then checksum wrap
    run_frame(0, 1'b1, "zero");
    if (last_w.size() == 4) check("zero_cksum_literal", last_w[3], 32'h0000);
    pay_q.push_back(16'hFFFF);
    pay_q.push_back(16'h0003);
    run_frame(2, 1'b1, "wrap");
    if (last_w.size() == 6) check("wrap_cksum_literal", last_w[5], 32'h0002);

    // Drops: a trigger mid-frame and one coincident with the checksum issue,
    // then a trigger in the very next (first idle) cycle is accepted.
    for (int i = 0; i < 8; i++) pay_q.push_back(16'($urandom));
    st_at[3]  = 1'b1;
    st_at[12] = 1'b1;
    run_frame(8, 1'b1, "drop");
    check("drop_literal", o_drop_cnt, 32'd2);
    pay_q.push_back(16'h5555);
    run_frame(1, 1'b1, "after_drop");

    // Triggers with i_en low are ignored and not counted
    i_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0, 1'b0, wr, d, busy);
      check("en_low_wr", {31'd0, wr}, 32'd0);
      check("en_low_busy", {31'd0, busy}, 32'd0);
    end
    check("en_low_drop", o_drop_cnt, exp_drop);
    check("en_low_seq", o_seq, exp_seq);
    i_en = 1'b1;

    // Randomized frames with random backpressure and FIFO underflow
    for (int f = 0; f < 24; f++) begin
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) pay_q.push_back(16'($urandom));
      for (int o = 1; o < 256; o++) begin
        full_at[o]  = ($urandom_range(0, 3) == 0);
        empty_at[o] = ($urandom_range(0, 3) == 0);
      end
      run_frame(len, 1'b0, $sformatf("rnd%0d", f));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step(1'b0, 1'b0, 1'b0, wr, d, busy);
        check("idle_gap_wr", {31'd0, wr}, 32'd0);
      end
    end

    // Reset in the middle of the payload
    for (int i = 0; i < 5; i++) cap_q.push_back(16'(16'h0100 + i));
    i_recv_count = 16'd5;
    step(1'b1, 1'b0, 1'b0, wr, d, busy);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, wr, d, busy);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_wr", {31'd0, o_wr}, 32'd0);
    check("midrst_wr_data", o_wr_data, 32'h0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_seq", o_seq, 32'hFFFF);
    check("midrst_drop", o_drop_cnt, 32'h0);
    check("midrst_rd", {31'd0, o_rd}, 32'd0);
    @(posedge i_clk); #1;
    check("midrst_rd_held", {31'd0, o_rd}, 32'd0);
    #2 i_rst = 1'b0;
    @(posedge i_clk); #1;
    cap_q.delete();
    exp_seq  = 16'hFFFF;
    exp_drop = 16'h0000;
    for (int i = 1; i <= 4; i++) pay_q.push_back(16'(i));
    run_frame(4, 1'b1, "post_rst");
    if (last_w.size() >= 2) begin
      check("post_rst_sync", last_w[0], 32'hA55A);
      check("post_rst_seq0", last_w[1], 32'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
